// File: rtl/xorshift_tile_picker.sv
// Xorshift random unit with a seeded generator and a random empty-cell picker
// (rejection sampling, falling back to a linear scan) for tile spawning.
module xorshift_tile_picker #(
  parameter int unsigned       WIDTH        = 32,
  parameter int unsigned       SH1          = 7,
  parameter int unsigned       SH2          = 9,
  parameter int unsigned       SH3          = 13,
  parameter logic [WIDTH-1:0]  DEFAULT_SEED = WIDTH'(32'h2545F491),
  parameter int unsigned       CELLS        = 16,
  parameter int unsigned       IDX_W        = 4,
  parameter int unsigned       PROB_W       = 2,
  parameter int unsigned       FOUR_NUM     = 1,
  parameter int unsigned       MAX_TRIES    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] seed,
  input  logic             seed_load,
  input  logic             req,
  input  logic [CELLS-1:0] empty_mask,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [IDX_W-1:0] cell_idx,
  output logic             two_or_four,
  output logic [WIDTH-1:0] rand_out
);

  localparam int unsigned TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_SCAN,
    ST_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CELLS-1:0]   mask_q, mask_d;
  logic [TRY_W-1:0]   tries_q, tries_d;
  logic [IDX_W-1:0]   scan_q, scan_d;
  logic               busy_d, done_d, found_d, tof_d;
  logic [IDX_W-1:0]   idx_d;

  logic [WIDTH-1:0]   xs_t, xs_u, xs_next;
  logic [IDX_W-1:0]   cand;
  logic [PROB_W-1:0]  pfield;
  logic [CELLS-1:0]   cand_sel, scan_sel;
  logic               cand_hit, scan_hit, tof_c;

  // One xorshift step; a nonzero state never maps to zero
  always_comb begin
    xs_t    = rand_out ^ (rand_out >> SH1);
    xs_u    = xs_t ^ (xs_t << SH2);
    xs_next = xs_u ^ (xs_u >> SH3);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rand_out <= DEFAULT_SEED;
    end else if (seed_load) begin
      rand_out <= (seed == '0) ? DEFAULT_SEED : seed;
    end else begin
      rand_out <= xs_next;
    end
  end

  // Shifting past the mask width yields 0, so out-of-range candidates miss
  always_comb begin
    cand     = rand_out[IDX_W-1:0];
    pfield   = rand_out[IDX_W+PROB_W-1:IDX_W];
    cand_sel = mask_q >> cand;
    scan_sel = mask_q >> scan_q;
    cand_hit = cand_sel[0];
    scan_hit = scan_sel[0];
    tof_c    = !(32'(pfield) < FOUR_NUM);
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    tries_d = tries_q;
    scan_d  = scan_q;
    done_d  = 1'b0;
    found_d = found;
    idx_d   = cell_idx;
    tof_d   = two_or_four;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          mask_d  = empty_mask;
          tries_d = '0;
          if (empty_mask == '0) begin
            found_d = 1'b0;
            idx_d   = '0;
            state_d = ST_DONE;
          end else begin
            state_d = ST_SAMPLE;
          end
        end
      end
      ST_SAMPLE: begin
        if (cand_hit) begin
          idx_d   = cand;
          tof_d   = tof_c;
          found_d = 1'b1;
          state_d = ST_DONE;
        end else if (32'(tries_q) == MAX_TRIES - 1) begin
          scan_d  = IDX_W'(32'(cand) % CELLS);
          state_d = ST_SCAN;
        end else begin
          tries_d = tries_q + TRY_W'(1);
        end
      end
      ST_SCAN: begin
        if (scan_hit) begin
          idx_d   = scan_q;
          tof_d   = tof_c;
          found_d = 1'b1;
          state_d = ST_DONE;
        end else if (32'(scan_q) == CELLS - 1) begin
          scan_d = '0;
        end else begin
          scan_d = scan_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      mask_q      <= '0;
      tries_q     <= '0;
      scan_q      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      found       <= 1'b0;
      cell_idx    <= '0;
      two_or_four <= 1'b1;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      tries_q     <= tries_d;
      scan_q      <= scan_d;
      busy        <= busy_d;
      done        <= done_d;
      found       <= found_d;
      cell_idx    <= idx_d;
      two_or_four <= tof_d;
    end
  end

endmodule
